// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, response and memory-port signals around the SNN memory
// port arbiter. The arbiter connects through the slave modport. The environment
// (requesters plus memory) connects through the master modport.
interface mem_port_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int XY_W   = 3,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_we;
  logic [2*NREQ-1:0]      req_sel;
  logic [XY_W*NREQ-1:0]   req_x;
  logic [XY_W*NREQ-1:0]   req_y;
  logic [DATA_W*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic                   mem_valid;
  logic                   mem_ready;
  logic                   mem_we;
  logic [1:0]             mem_sel;
  logic [XY_W-1:0]        mem_x;
  logic [XY_W-1:0]        mem_y;
  logic [DATA_W-1:0]      mem_wdata;
  logic                   mem_rvalid;
  logic [DATA_W-1:0]      mem_rdata;
  logic [1:0]             grant_id;
  logic                   busy;
  logic                   err_timeout;

  modport slave (
    input  req_valid, req_last, req_we, req_sel, req_x, req_y, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_data,
    output mem_valid, mem_we, mem_sel, mem_x, mem_y, mem_wdata,
    output grant_id, busy, err_timeout
  );

  modport master (
    output req_valid, req_last, req_we, req_sel, req_x, req_y, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_data,
    input  mem_valid, mem_we, mem_sel, mem_x, mem_y, mem_wdata,
    input  grant_id, busy, err_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Burst-granting round-robin arbiter that shares the single SNN memory port
// between the filter loader, the ifmap streamer and the writeback path. Only
// one memory transaction is in flight at a time. Reads that never return are
// answered with zero data and raise a sticky timeout flag.
module mem_port_arbiter #(
  parameter int NREQ      = 3,
  parameter int XY_W      = 3,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 5,
  parameter int LOCK_TO   = 16,
  parameter int MEM_TO    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int BC_W = $clog2(BURST_MAX + 1);
  localparam int LK_W = $clog2(LOCK_TO + 1);
  localparam int TO_W = $clog2(MEM_TO + 1);

  // The end of a beat is folded into the edge that completes it, so there is
  // no separate done state.
  typedef enum logic [1:0] {IDLE, ACCEPT, ISSUE, WAIT} state_t;

  state_t            state_q;
  logic [1:0]        grant_q;
  logic [1:0]        rr_ptr_q;
  logic [BC_W-1:0]   beat_cnt_q;
  logic [LK_W-1:0]   lock_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              last_q;
  logic              mem_valid_q;
  logic              mem_we_q;
  logic [1:0]        mem_sel_q;
  logic [XY_W-1:0]   mem_x_q;
  logic [XY_W-1:0]   mem_y_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              err_q;

  logic              pick_vld;
  logic [1:0]        pick_id;
  logic [1:0]        scan_idx;
  logic [NREQ-1:0]   g_oh;
  logic              g_valid;
  logic              g_last;
  logic              g_we;
  logic [1:0]        g_sel;
  logic [XY_W-1:0]   g_x;
  logic [XY_W-1:0]   g_y;
  logic [DATA_W-1:0] g_wdata;
  logic              rd_expire;
  logic              beat_end;
  logic              lock_exp;
  logic              release_grant;

  // Round-robin pick: lowest offset from rr_ptr with a valid request wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    scan_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan_idx = 2'((int'(rr_ptr_q) + i) % NREQ);
      if (bus.req_valid[scan_idx]) begin
        pick_vld = 1'b1;
        pick_id  = scan_idx;
      end
    end
  end

  // Route the current owner's request fields onto a single set of wires.
  always_comb begin
    g_oh    = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_we    = 1'b0;
    g_sel   = '0;
    g_x     = '0;
    g_y     = '0;
    g_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == 2'(i)) begin
        g_oh[i] = 1'b1;
        g_valid = bus.req_valid[i];
        g_last  = bus.req_last[i];
        g_we    = bus.req_we[i];
        g_sel   = bus.req_sel[2*i +: 2];
        g_x     = bus.req_x[i*XY_W +: XY_W];
        g_y     = bus.req_y[i*XY_W +: XY_W];
        g_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Beat completion and grant release conditions for this cycle.
  always_comb begin
    rd_expire     = (to_cnt_q == TO_W'(MEM_TO - 1));
    beat_end      = ((state_q == ISSUE) && bus.mem_ready && mem_we_q) ||
                    ((state_q == WAIT) && (bus.mem_rvalid || rd_expire));
    lock_exp      = (state_q == ACCEPT) && !g_valid &&
                    (lock_cnt_q == LK_W'(LOCK_TO - 1));
    release_grant = (beat_end && last_q) || lock_exp;
  end

  // Arbiter FSM with registered memory command, response and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      to_cnt_q    <= '0;
      last_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= '0;
      mem_x_q     <= '0;
      mem_y_q     <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q    <= pick_id;
            lock_cnt_q <= '0;
            state_q    <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (g_valid) begin
            mem_we_q    <= g_we;
            mem_sel_q   <= g_sel;
            mem_x_q     <= g_x;
            mem_y_q     <= g_y;
            mem_wdata_q <= g_wdata;
            mem_valid_q <= 1'b1;
            last_q      <= g_last | (beat_cnt_q == BC_W'(BURST_MAX - 1));
            beat_cnt_q  <= beat_cnt_q + BC_W'(1);
            state_q     <= ISSUE;
          end else begin
            lock_cnt_q  <= lock_cnt_q + LK_W'(1);
          end
        end
        ISSUE: begin
          if (bus.mem_ready) begin
            mem_valid_q <= 1'b0;
            if (!mem_we_q) begin
              to_cnt_q <= '0;
              state_q  <= WAIT;
            end
          end
        end
        WAIT: begin
          // Returned data beats an expiring timer on the same cycle.
          if (bus.mem_rvalid) begin
            rsp_data_q  <= bus.mem_rdata;
            rsp_valid_q <= g_oh;
          end else if (rd_expire) begin
            rsp_data_q  <= '0;
            rsp_valid_q <= g_oh;
            err_q       <= 1'b1;
          end else begin
            to_cnt_q    <= to_cnt_q + TO_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
      if (beat_end) begin
        lock_cnt_q <= '0;
        state_q    <= ACCEPT;
      end
      if (release_grant) begin
        rr_ptr_q   <= 2'((int'(grant_q) + 1) % NREQ);
        beat_cnt_q <= '0;
        state_q    <= IDLE;
      end
    end
  end

  assign bus.req_ready   = (state_q == ACCEPT) ? g_oh : '0;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.mem_valid   = mem_valid_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_sel     = mem_sel_q;
  assign bus.mem_x       = mem_x_q;
  assign bus.mem_y       = mem_y_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-requester beat queues, a memory
// responder with programmable read latency, and logs of issued commands and
// response strobes.
module tb_mem_port_arbiter;
  localparam int NREQ    = 3;
  localparam int XY_W    = 3;
  localparam int DATA_W  = 8;
  localparam int LOCK_TO = 16;
  localparam int MEM_TO  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NREQ(NREQ), .XY_W(XY_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .NREQ(NREQ), .XY_W(XY_W), .DATA_W(DATA_W),
    .BURST_MAX(5), .LOCK_TO(LOCK_TO), .MEM_TO(MEM_TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic       we;
    logic [1:0] sel;
    logic [2:0] x;
    logic [2:0] y;
    logic [7:0] wdata;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [1:0] gid;
    logic       we;
    logic [1:0] sel;
    logic [2:0] x;
    logic [2:0] y;
    logic [7:0] wdata;
    int         cyc;
  } cmd_t;

  beat_t           rq [NREQ][$];
  cmd_t            cmds [$];
  int              n_chk = 0;
  int              n_fail = 0;
  int              cyc = 0;
  logic [NREQ-1:0] acc;
  int              rd_lat;
  logic [7:0]      rd_val;
  bit              rd_pend;
  int              rd_wait;
  int              rsp_cnt;
  int              rsp_cyc;
  logic [NREQ-1:0] rsp_vec;
  logic [7:0]      rsp_dat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic we, input logic [1:0] sel, input logic [2:0] x,
                               input logic [2:0] y, input logic [7:0] wdata, input logic last);
    beat_t b;
    b.we = we; b.sel = sel; b.x = x; b.y = y; b.wdata = wdata; b.last = last;
    return b;
  endfunction

  task automatic present();
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        bus.req_valid[i]              = 1'b1;
        bus.req_we[i]                 = rq[i][0].we;
        bus.req_last[i]               = rq[i][0].last;
        bus.req_sel[2*i +: 2]         = rq[i][0].sel;
        bus.req_x[3*i +: 3]           = rq[i][0].x;
        bus.req_y[3*i +: 3]           = rq[i][0].y;
        bus.req_wdata[8*i +: 8]       = rq[i][0].wdata;
      end else begin
        bus.req_valid[i] = 1'b0;
      end
    end
  endtask

  // One clock: retire accepted beats, present queue heads, run the memory model, log.
  task automatic step();
    cmd_t c;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) if (acc[i]) rq[i].delete(0);
    present();
    bus.mem_rvalid = 1'b0;
    if (rd_pend) begin
      if (rd_wait == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rd_val;
        rd_pend        = 1'b0;
      end else begin
        rd_wait--;
      end
    end
    if (bus.mem_valid && bus.mem_ready) begin
      c.gid = bus.grant_id; c.we = bus.mem_we; c.sel = bus.mem_sel; c.x = bus.mem_x;
      c.y = bus.mem_y; c.wdata = bus.mem_wdata; c.cyc = cyc;
      cmds.push_back(c);
      if (!bus.mem_we && rd_lat >= 0) begin
        rd_pend = 1'b1;
        rd_wait = rd_lat;
      end
    end
    acc = bus.req_valid & bus.req_ready;
    if (bus.rsp_valid != '0) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      rsp_vec = bus.rsp_valid;
      rsp_dat = bus.rsp_data;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    cmds.delete();
    acc = '0; rd_pend = 1'b0; rd_wait = 0; rsp_cnt = 0; rsp_cyc = 0;
    bus.req_valid = '0; bus.req_last = '0; bus.req_we = '0; bus.req_sel = '0;
    bus.req_x = '0; bus.req_y = '0; bus.req_wdata = '0;
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run(input string tag, input int budget);
    int  n = 0;
    bit  done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = (rq[0].size() == 0) && (rq[1].size() == 0) && (rq[2].size() == 0) &&
             (acc == '0) && !bus.busy && !rd_pend;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  int exp_gid [6]  = '{0, 1, 2, 0, 1, 2};
  int exp_t3 [6]   = '{1, 1, 1, 1, 1, 2};
  int exp_t3y [6]  = '{0, 1, 2, 3, 4, 3};
  int exp_t4 [9]   = '{0, 1, 1, 1, 1, 1, 2, 1, 1};
  int exp_t4y [9]  = '{7, 0, 1, 2, 3, 4, 6, 5, 6};

  initial begin
    rd_lat = 0; rd_val = 8'hA5;
    // Reset state and single read from requester 0.
    do_reset();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_outs", {bus.mem_valid, bus.req_ready, bus.rsp_valid, bus.grant_id,
                       bus.err_timeout, bus.rsp_data}, 32'd0);
    rd_lat = 3; rd_val = 8'h5A;
    rq[0].push_back(mk(1'b0, 2'd2, 3'd1, 3'd2, 8'h00, 1'b1));
    step();
    check("t1_c0_ready", 32'(bus.req_ready), 32'd0);
    step();
    check("t1_c1_ready", 32'(bus.req_ready), 32'b001);
    check("t1_c1_gid", 32'(bus.grant_id), 32'd0);
    step();
    check("t1_c2_mvalid", 32'(bus.mem_valid), 32'd1);
    check("t1_c2_fields", {bus.mem_we, bus.mem_sel, bus.mem_x, bus.mem_y}, {1'b0, 2'd2, 3'd1, 3'd2});
    repeat (4) step();
    check("t1_c6_rsp", 32'(bus.rsp_valid), 32'd0);
    step();
    check("t1_c7_rsp", 32'(bus.rsp_valid), 32'b001);
    check("t1_c7_data", 32'(bus.rsp_data), 32'h5A);
    check("t1_c7_busy", 32'(bus.busy), 32'd0);
    step();
    check("t1_c8_rsp", 32'(bus.rsp_valid), 32'd0);

    // Round robin among three continuous single-beat readers.
    do_reset();
    rd_lat = 0; rd_val = 8'hA5;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++) rq[i].push_back(mk(1'b0, 2'(2 - i), 3'(i), 3'(k), 8'h00, 1'b1));
    run("t2", 200);
    check("t2_ncmd", cmds.size(), 32'd6);
    check("t2_nrsp", rsp_cnt, 32'd6);
    for (int k = 0; k < 6; k++) check($sformatf("t2_gid%0d", k), 32'(cmds[k].gid), exp_gid[k]);

    // Five-beat ifmap burst from requester 1 while requester 2 waits.
    cmds.delete(); rsp_cnt = 0;
    for (int y = 0; y < 5; y++) rq[1].push_back(mk(1'b0, 2'd1, 3'd0, 3'(y), 8'h00, y == 4));
    rq[2].push_back(mk(1'b0, 2'd0, 3'd3, 3'd3, 8'h00, 1'b1));
    run("t3", 300);
    check("t3_ncmd", cmds.size(), 32'd6);
    for (int k = 0; k < 6; k++)
      check($sformatf("t3_beat%0d", k), {cmds[k].gid, cmds[k].y}, {2'(exp_t3[k]), 3'(exp_t3y[k])});

    // Seven beats without last: capped at five, remainder re-arbitrated, lock release.
    cmds.delete(); rsp_cnt = 0;
    rq[0].push_back(mk(1'b0, 2'd2, 3'd0, 3'd7, 8'h00, 1'b1));
    for (int y = 0; y < 7; y++) rq[1].push_back(mk(1'b0, 2'd1, 3'd1, 3'(y), 8'h00, 1'b0));
    rq[2].push_back(mk(1'b0, 2'd0, 3'd2, 3'd6, 8'h00, 1'b1));
    run("t4", 400);
    check("t4_ncmd", cmds.size(), 32'd9);
    for (int k = 0; k < 9; k++)
      check($sformatf("t4_beat%0d", k), {cmds[k].gid, cmds[k].y}, {2'(exp_t4[k]), 3'(exp_t4y[k])});
    check("t4_lock", cyc - rsp_cyc, LOCK_TO);

    // Mempot write: no response strobe.
    cmds.delete(); rsp_cnt = 0;
    rq[2].push_back(mk(1'b1, 2'd0, 3'd2, 3'd1, 8'h33, 1'b1));
    run("t5w", 100);
    check("t5w_ncmd", cmds.size(), 32'd1);
    check("t5w_fields", {cmds[0].gid, cmds[0].we, cmds[0].sel, cmds[0].x, cmds[0].y, cmds[0].wdata},
          {2'd2, 1'b1, 2'd0, 3'd2, 3'd1, 8'h33});
    check("t5w_nrsp", rsp_cnt, 32'd0);

    // Data on the last timer cycle wins over expiry.
    cmds.delete(); rsp_cnt = 0; rd_lat = MEM_TO - 1; rd_val = 8'hC3;
    rq[0].push_back(mk(1'b0, 2'd2, 3'd4, 3'd4, 8'h00, 1'b1));
    run("t5e", 100);
    check("t5e_lat", rsp_cyc - cmds[0].cyc, MEM_TO + 1);
    check("t5e_data", 32'(rsp_dat), 32'hC3);
    check("t5e_err", 32'(bus.err_timeout), 32'd0);

    // Read that never returns.
    cmds.delete(); rsp_cnt = 0; rd_lat = -1;
    rq[0].push_back(mk(1'b0, 2'd2, 3'd5, 3'd5, 8'h00, 1'b1));
    run("t5t", 100);
    check("t5t_lat", rsp_cyc - cmds[0].cyc, MEM_TO + 1);
    check("t5t_vec", 32'(rsp_vec), 32'b001);
    check("t5t_data", 32'(rsp_dat), 32'h00);
    check("t5t_err", 32'(bus.err_timeout), 32'd1);
    repeat (3) step();
    check("t5t_sticky", 32'(bus.err_timeout), 32'd1);

    // Asynchronous reset while a read is outstanding.
    cmds.delete();
    rq[1].push_back(mk(1'b0, 2'd1, 3'd6, 3'd2, 8'h00, 1'b1));
    for (int n = 0; n < 20 && cmds.size() == 0; n++) step();
    check("t5r_issued", cmds.size(), 32'd1);
    repeat (5) step();
    check("t5r_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #2;
    check("t5r_ctl", {bus.busy, bus.mem_valid, bus.err_timeout, bus.grant_id, bus.req_ready,
                      bus.rsp_valid}, 32'd0);
    check("t5r_data", {bus.rsp_data, bus.mem_we, bus.mem_sel, bus.mem_x, bus.mem_y, bus.mem_wdata},
          32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
